// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider that stalls the pipeline while it runs.
// Optional signed support: define MCYCLE_SIGNED_EN to add the IsSigned input.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
`ifdef MCYCLE_SIGNED_EN
  input  logic             IsSigned,
`endif
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     res1_q, res1_d;
  logic [WIDTH-1:0]     res2_q, res2_d;

  logic                 sgn;
  logic                 neg1, neg2;
  logic [WIDTH-1:0]     mag1, mag2;

`ifdef MCYCLE_SIGNED_EN
  assign sgn = IsSigned;
`else
  assign sgn = 1'b0;
`endif

  assign neg1 = sgn & Operand1[WIDTH-1];
  assign neg2 = sgn & Operand2[WIDTH-1];
  assign mag1 = neg1 ? -Operand1 : Operand1;
  assign mag2 = neg2 ? -Operand2 : Operand2;

  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       dsh;
  logic [WIDTH:0]       ddiff;
  logic                 dge;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   fin_p;
  logic [WIDTH-1:0]     fq;
  logic [WIDTH-1:0]     fr;

  // acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div
  always_comb begin
    msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (acc_q[0] ? {1'b0, b_q} : '0);
    dsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ddiff = dsh - {1'b0, b_q};
    dge   = (dsh >= {1'b0, b_q});
    if (op_q)
      step = {(dge ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0]),
              acc_q[WIDTH-2:0], dge};
    else
      step = {msum, acc_q[WIDTH-1:1]};
  end

  // Divide-by-zero keeps quotient all ones; remainder sign restores Operand1
  always_comb begin
    fin_p = (s1_q ^ s2_q) ? -step : step;
    fq    = step[WIDTH-1:0];
    if ((s1_q ^ s2_q) && (b_q != '0))
      fq = -fq;
    fr    = step[2*WIDTH-1:WIDTH];
    if (s1_q)
      fr = -fr;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          op_d    = MCycleOp;
          s1_d    = neg1;
          s2_d    = neg2;
          acc_d   = {{WIDTH{1'b0}}, (MCycleOp ? mag1 : mag2)};
          b_d     = MCycleOp ? mag2 : mag1;
        end
      end
      COMPUTE: begin
        acc_d = step;
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (op_q) begin
            res1_d = fq;
            res2_d = fr;
          end else begin
            res1_d = fin_p[WIDTH-1:0];
            res2_d = fin_p[2*WIDTH-1:WIDTH];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  // Gated by RESETn so a held Start cannot stall the pipeline during reset
  assign Busy = RESETn &
                (((state_q == IDLE) & Start) | (state_q == COMPUTE));
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed-vector bench for mcycle_unit (WIDTH=32).
// Signed vectors are added when MCYCLE_SIGNED_EN is defined.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic        MCycleOp = 1'b0;
`ifdef MCYCLE_SIGNED_EN
  logic        IsSigned = 1'b0;
`endif
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;

  int vecs = 0;
  int errs = 0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
`ifdef MCYCLE_SIGNED_EN
    .IsSigned (IsSigned),
`endif
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start held until Busy falls; operands are scrambled mid-operation
  task automatic run_op(input string tag, input logic op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
    int n;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    #1;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 3) begin
        Operand1 = ~a;
        Operand2 = a ^ b;
        MCycleOp = ~op;
      end
      @(posedge CLK);
      #1;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_r1"}, {32'd0, Result1}, {32'd0, e1});
    chk({tag, "_r2"}, {32'd0, Result2}, {32'd0, e2});
    Start = 1'b0;
    @(posedge CLK);
    #1;
    chk({tag, "_hold"}, {Result2, Result1}, {e2, e1});
    chk({tag, "_idle"}, {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_r1", {32'd0, Result1}, 64'd0);
    chk("rst_r2", {32'd0, Result2}, 64'd0);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("div5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    MCycleOp = 1'b0;
    Operand1 = 32'd9;
    Operand2 = 32'd11;
    Start    = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    RESETn = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_r1", {32'd0, Result1}, 64'd0);
    chk("midrst_r2", {32'd0, Result2}, 64'd0);
    Start = 1'b0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    run_op("mul123x456", 1'b0, 32'd123, 32'd456, 32'd56088, 32'd0);

    MCycleOp = 1'b0;
    Operand1 = 32'd3;
    Operand2 = 32'd5;
    Start    = 1'b1;
    for (int i = 0; i < 80; i++) begin
      #1;
      chk("cont_busy", {63'd0, Busy}, {63'd0, ((i % 34) != 33)});
      if (i == 33)
        chk("cont_r1", {32'd0, Result1}, 64'd15);
      @(posedge CLK);
    end
    #1;
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(posedge CLK);
      #1;
    end
    chk("cont_drain", {63'd0, Busy}, 64'd0);
    chk("cont_final", {Result2, Result1}, {32'd0, 32'd15});
    @(posedge CLK);
    #1;

`ifdef MCYCLE_SIGNED_EN
    IsSigned = 1'b1;
    run_op("smul", 1'b0, -32'sd7, 32'd3, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    run_op("sdiv", 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("sdiv0", 1'b1, -32'sd9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    IsSigned = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
